accum_cmd_queue: RTL and testbench

Two-lane command queue that sits directly upstream of the dual-accumulator pipeline and drives its per-lane `cmd_vld`/`opcode` inputs. It buffers opcodes from a single valid/ready producer into one FIFO per lane and issues them one per lane per cycle. It stops issuing after a halt opcode (3'b111) goes out, then tracks the downstream `halt` return until it reaches a sticky halted state.

---
 rtl/accum_cmd_queue.sv | 223 ++++++++++++++++++++++
 tb/tb_accum_cmd_queue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_cmd_queue.sv
// accum_cmd_queue
// ---------------------------------------------------------------------------
// Command queue for a two-lane accumulator pipeline. A single producer
// supplies opcodes. The queue keeps one circular FIFO per lane and issues at
// most one opcode per lane per cycle to the pipeline, through the registered
// cmd_vld/opcode pair.
//
// Issuing stops once a halt opcode (3'b111) goes out. The queue then waits in
// HALT_PEND for the pipeline's halt return. If the return arrives, the queue
// enters HALTED, which is sticky until reset. If it does not arrive within
// HALT_TIMEOUT cycles, halt_timeout_err is set and issuing resumes.
//
// Handshake (producer side):
//   A transfer happens at a rising edge where in_valid && in_ready are both 1.
//   in_ready depends only on the registered occupancy of the lane selected by
//   in_lane, plus the FSM state. It does not depend on in_valid or on a pop
//   that happens in the same cycle. The producer may change in_lane while it
//   holds in_valid; the transfer targets whatever lane is presented at the
//   edge.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   in_valid/in_ready producer handshake
//   in_lane           target lane of the presented command
//   in_opcode         command opcode (3'b111 = halt; all others pass through)
//   cmd_vld[l]        per-lane issue strobe (registered)
//   opcode[l]         per-lane issued opcode (registered, held when idle)
//   halt              halt return from the accumulator pipeline
//   lane_count[l]     per-lane FIFO occupancy (0..DEPTH)
//   halted            1 while in HALTED
//   halt_timeout_err  sticky: halt return missed its window
//   fsm_state         debug view of the FSM: 0 RUN, 1 HALT_PEND, 2 HALTED
// ---------------------------------------------------------------------------
module accum_cmd_queue #(
    parameter int DEPTH        = 4,
    parameter int HALT_TIMEOUT = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_lane,
    input  logic [2:0]                            in_opcode,
    output logic [1:0]                            cmd_vld,
    output logic [1:0][2:0]                       opcode,
    input  logic                                  halt,
    output logic [1:0][$clog2(DEPTH+1)-1:0]       lane_count,
    output logic                                  halted,
    output logic                                  halt_timeout_err,
    output logic [1:0]                            fsm_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(HALT_TIMEOUT);

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LAST = WW'(HALT_TIMEOUT - 1);
    localparam logic [2:0]    OP_HALT   = 3'b111;

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_HALT_PEND = 2'd1,
        S_HALTED    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // FIFO storage and bookkeeping, one set per lane.
    logic [2:0]    mem    [2][DEPTH];
    logic [PW-1:0] wr_ptr [2];
    logic [PW-1:0] rd_ptr [2];
    logic [CW-1:0] count  [2];

    logic [WW-1:0] wait_cnt;
    logic          err_q;

    // Combinational control.
    logic [1:0]    full;
    logic [1:0]    empty;
    logic [2:0]    head   [2];
    logic          wr_en;
    logic [1:0]    wr_lane;
    logic [1:0]    pop;
    logic          halt_popped;
    logic          err_set;

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        full        = '0;
        empty       = '0;
        pop         = '0;
        halt_popped = 1'b0;
        err_set     = 1'b0;
        state_next  = state;

        for (int l = 0; l < 2; l++) begin
            full[l]  = (count[l] == FULL_CNT);
            empty[l] = (count[l] == '0);
            head[l]  = mem[l][rd_ptr[l]];
        end

        // A full lane refuses a write even if it pops in this cycle.
        in_ready   = !full[in_lane] && (state != S_HALTED);
        wr_en      = in_valid && in_ready;
        wr_lane[0] = wr_en && !in_lane;
        wr_lane[1] = wr_en &&  in_lane;

        case (state)
            S_RUN: begin
                if (halt) begin
                    // A halt return with no halt outstanding: stop right away.
                    state_next = S_HALTED;
                end else begin
                    for (int l = 0; l < 2; l++) begin
                        pop[l] = !empty[l];
                        if (pop[l] && (head[l] == OP_HALT)) begin
                            halt_popped = 1'b1;
                        end
                    end
                    // The other lane's pop in this cycle still issues.
                    if (halt_popped) begin
                        state_next = S_HALT_PEND;
                    end
                end
            end

            S_HALT_PEND: begin
                // A halt return in the last wait cycle wins over the timeout.
                if (halt) begin
                    state_next = S_HALTED;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_set    = 1'b1;
                    state_next = S_RUN;
                end
            end

            S_HALTED: begin
                state_next = S_HALTED;
            end

            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO storage. Not reset: pointers and counts define what is valid.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (wr_lane[l]) begin
                mem[l][wr_ptr[l]] <= in_opcode;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State, pointers, counters and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            cmd_vld  <= '0;
            opcode   <= '0;
            for (int l = 0; l < 2; l++) begin
                wr_ptr[l] <= '0;
                rd_ptr[l] <= '0;
                count[l]  <= '0;
            end
        end else begin
            state <= state_next;

            if (state == S_RUN) begin
                wait_cnt <= '0;
            end else if (state == S_HALT_PEND) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (err_set) begin
                err_q <= 1'b1;
            end

            for (int l = 0; l < 2; l++) begin
                // DEPTH is a power of two, so pointers wrap by overflow.
                if (wr_lane[l]) begin
                    wr_ptr[l] <= wr_ptr[l] + 1'b1;
                end
                if (pop[l]) begin
                    rd_ptr[l] <= rd_ptr[l] + 1'b1;
                    opcode[l] <= head[l];
                end
                cmd_vld[l] <= pop[l];

                case ({wr_lane[l], pop[l]})
                    2'b10:   count[l] <= count[l] + 1'b1;
                    2'b01:   count[l] <= count[l] - 1'b1;
                    default: count[l] <= count[l];
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Status outputs
    // -----------------------------------------------------------------------
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            lane_count[l] = count[l];
        end
    end

    assign halted           = (state == S_HALTED);
    assign halt_timeout_err = err_q;
    assign fsm_state        = state;

endmodule

// File: tb/tb_accum_cmd_queue.sv
// Directed testbench for accum_cmd_queue (DEPTH=4, HALT_TIMEOUT=8).
// Inputs are driven 1 time unit after each rising edge. Outputs are checked
// in the same window, after a further 1-unit settle when in_ready depends on
// an input that was just driven.
module tb_accum_cmd_queue;

    localparam int DEPTH        = 4;
    localparam int HALT_TIMEOUT = 8;
    localparam int CW           = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_HALT_PEND = 2'd1;
    localparam logic [1:0] ST_HALTED    = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_lane;
    logic [2:0]             in_opcode;
    logic [1:0]             cmd_vld;
    logic [1:0][2:0]        opcode;
    logic                   halt;
    logic [1:0][CW-1:0]     lane_count;
    logic                   halted;
    logic                   halt_timeout_err;
    logic [1:0]             fsm_state;

    accum_cmd_queue #(
        .DEPTH        (DEPTH),
        .HALT_TIMEOUT (HALT_TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_lane          (in_lane),
        .in_opcode        (in_opcode),
        .cmd_vld          (cmd_vld),
        .opcode           (opcode),
        .halt             (halt),
        .lane_count       (lane_count),
        .halted           (halted),
        .halt_timeout_err (halt_timeout_err),
        .fsm_state        (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] exp_q0[$];
    logic [2:0] exp_q1[$];

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic lane, input logic [2:0] op);
        in_valid  = v;
        in_lane   = lane;
        in_opcode = op;
        #1;
    endtask

    // Time limit: the sequence is linear, so this only trips if time runs away.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "time limit");
    end

    // ---------------- stimulus and checks ----------------
    initial begin
        logic [2:0] stream_op [8];
        logic [1:0] exp_vld;
        logic [2:0] exp_op;

        stream_op[0] = 3'b001; stream_op[1] = 3'b010;
        stream_op[2] = 3'b100; stream_op[3] = 3'b011;
        stream_op[4] = 3'b101; stream_op[5] = 3'b110;
        stream_op[6] = 3'b010; stream_op[7] = 3'b001;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_lane   = 1'b0;
        in_opcode = 3'b000;
        halt      = 1'b0;

        // ===== Reset and single issue =====
        tick();                      // cycle 1 in reset
        tick();                      // cycle 2 in reset
        reset = 1'b0;                // cycle 3
        check("rst_cmd_vld",  cmd_vld,          2'b00);
        check("rst_opcode",   opcode,           6'o00);
        check("rst_count",    lane_count,       '0);
        check("rst_halted",   halted,           1'b0);
        check("rst_err",      halt_timeout_err, 1'b0);
        check("rst_state",    fsm_state,        ST_RUN);
        drive(1'b1, 1'b0, 3'b001);
        check("rst_in_ready", in_ready,         1'b1);
        tick();                      // cycle 4
        drive(1'b0, 1'b0, 3'b000);
        check("c4_count0",    lane_count[0],    3'd1);
        check("c4_cmd_vld",   cmd_vld,          2'b00);
        tick();                      // cycle 5
        check("c5_cmd_vld",   cmd_vld,          2'b01);
        check("c5_opcode0",   opcode[0],        3'b001);
        tick();                      // cycle 6
        check("c6_cmd_vld",   cmd_vld,          2'b00);
        check("c6_count0",    lane_count[0],    3'd0);

        // ===== Full boundary, timeout, dual-lane resume =====
        drive(1'b1, 1'b1, 3'b111);   // halt opcode on lane1
        tick();
        drive(1'b0, 1'b0, 3'b000);
        tick();                      // cycle A: halt issued
        check("fb_cmd_vld_A", cmd_vld,          2'b10);
        check("fb_opcode1_A", opcode[1],        3'b111);
        check("fb_state_A",   fsm_state,        ST_HALT_PEND);
        drive(1'b1, 1'b0, 3'b001); tick();   // A
        check("fb_no_issue",  cmd_vld,          2'b00);
        drive(1'b1, 1'b0, 3'b010); tick();   // A+1
        drive(1'b1, 1'b0, 3'b100); tick();   // A+2
        drive(1'b1, 1'b0, 3'b011); tick();   // A+3
        drive(1'b1, 1'b0, 3'b101);           // A+4: fifth push, refused
        check("fb_count0_4",  lane_count[0],    3'd4);
        check("fb_ready_full", in_ready,        1'b0);
        tick();                              // A+5
        check("fb_count0_held", lane_count[0],  3'd4);
        drive(1'b1, 1'b1, 3'b101);
        check("fb_ready_lane1", in_ready,       1'b1);
        tick();                              // A+6
        drive(1'b1, 1'b1, 3'b110);
        tick();                              // A+7
        drive(1'b0, 1'b0, 3'b000);
        check("to_err_early", halt_timeout_err, 1'b0);
        check("to_state_pend", fsm_state,       ST_HALT_PEND);
        check("fb_count1",    lane_count[1],    3'd2);
        tick();                              // A+8
        check("to_err_set",   halt_timeout_err, 1'b1);
        check("to_state_run", fsm_state,        ST_RUN);
        check("to_cmd_vld",   cmd_vld,          2'b00);
        tick();                              // A+9
        check("rs_vld_9",     cmd_vld,          2'b11);
        check("rs_op_9",      opcode,           {3'b101, 3'b001});
        tick();                              // A+10
        check("rs_vld_10",    cmd_vld,          2'b11);
        check("rs_op_10",     opcode,           {3'b110, 3'b010});
        tick();                              // A+11
        check("rs_vld_11",    cmd_vld,          2'b01);
        check("rs_op_11",     opcode,           {3'b110, 3'b100});
        tick();                              // A+12
        check("rs_vld_12",    cmd_vld,          2'b01);
        check("rs_op_12",     opcode,           {3'b110, 3'b011});
        tick();                              // A+13
        check("rs_vld_13",    cmd_vld,          2'b00);
        check("rs_count",     lane_count,       '0);

        // ===== Dual-lane streaming (pointers already past DEPTH on lane0) =====
        // A command pushed in stream cycle k issues in cycle k+2:
        // lane0 issues in cycles 2,4,6,8 and lane1 in cycles 3,5,7,9.
        for (int k = 0; k < 12; k++) begin
            exp_vld[0] = (k >= 2) && (k <= 8) && (k % 2 == 0);
            exp_vld[1] = (k >= 3) && (k <= 9) && (k % 2 == 1);
            check($sformatf("st_vld_%0d", k), cmd_vld, exp_vld);
            if (cmd_vld[0]) begin
                if (exp_q0.size() == 0) begin
                    check($sformatf("st_q0_empty_%0d", k), exp_q0.size(), 1);
                end else begin
                    exp_op = exp_q0.pop_front();
                    check($sformatf("st_op0_%0d", k), opcode[0], exp_op);
                end
            end
            if (cmd_vld[1]) begin
                if (exp_q1.size() == 0) begin
                    check($sformatf("st_q1_empty_%0d", k), exp_q1.size(), 1);
                end else begin
                    exp_op = exp_q1.pop_front();
                    check($sformatf("st_op1_%0d", k), opcode[1], exp_op);
                end
            end
            if (k < 8) begin
                drive(1'b1, (k % 2 == 1), stream_op[k]);
                check($sformatf("st_ready_%0d", k), in_ready, 1'b1);
                if (k % 2 == 1) exp_q1.push_back(stream_op[k]);
                else            exp_q0.push_back(stream_op[k]);
            end else begin
                drive(1'b0, 1'b0, 3'b000);
            end
            tick();
        end
        check("st_q0_drained", exp_q0.size(), 0);
        check("st_q1_drained", exp_q1.size(), 0);
        check("st_count",      lane_count,    '0);

        // ===== Halt round trip =====
        drive(1'b1, 1'b0, 3'b111); tick();   // H0
        drive(1'b1, 1'b0, 3'b001); tick();   // H1
        // cycle A: halt issued on lane0
        check("ht_vld_A",     cmd_vld,          2'b01);
        check("ht_op0_A",     opcode[0],        3'b111);
        check("ht_state_A",   fsm_state,        ST_HALT_PEND);
        drive(1'b1, 1'b1, 3'b010); tick();   // A+1
        drive(1'b1, 1'b1, 3'b100); tick();   // A+2
        drive(1'b0, 1'b0, 3'b000);
        check("ht_vld_A2",    cmd_vld,          2'b00);
        tick();                              // A+3
        check("ht_halted_A3", halted,           1'b0);
        tick();                              // A+4
        halt = 1'b1;
        check("ht_halted_A4", halted,           1'b0);
        tick();                              // A+5
        halt = 1'b0;
        check("ht_halted_A5", halted,           1'b1);
        check("ht_state_A5",  fsm_state,        ST_HALTED);
        check("ht_vld_A5",    cmd_vld,          2'b00);
        check("ht_ready0_A5", in_ready,         1'b0);
        drive(1'b1, 1'b1, 3'b011);
        check("ht_ready1_A5", in_ready,         1'b0);
        tick();                              // A+6
        drive(1'b0, 1'b0, 3'b000);
        check("ht_count_A6",  lane_count,       {3'd2, 3'd1});
        check("ht_vld_A6",    cmd_vld,          2'b00);
        check("ht_op_A6",     opcode,           {3'b001, 3'b111});
        tick();                              // A+7
        check("ht_vld_A7",    cmd_vld,          2'b00);
        check("ht_halted_A7", halted,           1'b1);

        // ===== Reset while HALTED with 3 entries queued =====
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_count",     lane_count,       '0);
        check("mr_halted",    halted,           1'b0);
        check("mr_cmd_vld",   cmd_vld,          2'b00);
        check("mr_opcode",    opcode,           6'o00);
        check("mr_err",       halt_timeout_err, 1'b0);
        check("mr_state",     fsm_state,        ST_RUN);
        drive(1'b1, 1'b1, 3'b011);
        check("mr_ready",     in_ready,         1'b1);
        tick();
        drive(1'b0, 1'b0, 3'b000);
        check("mr_vld_t1",    cmd_vld,          2'b00);
        check("mr_count_t1",  lane_count[1],    3'd1);
        tick();
        check("mr_vld_t2",    cmd_vld,          2'b10);
        check("mr_op_t2",     opcode,           {3'b011, 3'b000});
        tick();
        check("mr_vld_t3",    cmd_vld,          2'b00);
        check("mr_count_t3",  lane_count,       '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
